risc_run_ctrl: RTL and testbench

RISC_RUN_CTRL -- requirements
Module: risc_run_ctrl

---
 rtl/risc_run_ctrl_pkg.sv | 39 +++
 rtl/risc_stall_detect.sv | 46 ++++
 rtl/risc_run_ctrl.sv | 106 ++++++++++
 tb/tb_risc_run_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encoding, end-of-run
// cause encoding, default parameter values and the end-cause priority helper.
package risc_run_ctrl_pkg;

   localparam int unsigned   DEF_PC_WIDTH     = 16;
   localparam int unsigned   DEF_CNT_WIDTH    = 32;
   localparam int unsigned   DEF_RESET_CYCLES = 4;
   localparam int unsigned   DEF_MAX_CYCLES   = 1000;
   localparam int unsigned   DEF_STALL_LIMIT  = 8;
   localparam logic [15:0]   DEF_HALT_PC      = 16'h0000;

   // RESET_CYCLES and STALL_LIMIT are both capped at 255
   localparam int unsigned   RESET_CNT_WIDTH  = 8;
   localparam int unsigned   STALL_CNT_WIDTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      END_NONE    = 2'd0,
      END_HALT    = 2'd1,
      END_STALL   = 2'd2,
      END_TIMEOUT = 2'd3
   } end_cause_t;

   // Several end conditions may coincide; halt beats stall beats timeout
   function automatic end_cause_t pick_end(input logic halt, input logic stalled,
                                           input logic expired);
      if (halt)         return END_HALT;
      else if (stalled) return END_STALL;
      else if (expired) return END_TIMEOUT;
      else              return END_NONE;
   endfunction

endpackage

// File: rtl/risc_stall_detect.sv
// Self-loop detector: remembers the previous pc and counts consecutive cycles
// in which pc has not changed. The count is held at zero outside RUN, so every
// run starts with a fresh count.
module risc_stall_detect
   import risc_run_ctrl_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
   parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                stall_hit
);

   localparam logic [STALL_CNT_WIDTH-1:0] STALL_LAST = STALL_CNT_WIDTH'(STALL_LIMIT - 1);

   logic [PC_WIDTH-1:0]        prev_pc;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt;
   logic [STALL_CNT_WIDTH-1:0] cnt_next;
   logic                       same;

   // Compare against the previous pc and flag the cycle the count reaches the limit
   // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
   always_comb begin
      same      = (pc == prev_pc);
      cnt_next  = '0;
      if (same)
         cnt_next = (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_CNT_WIDTH'(1);
      stall_hit = en && same && (cnt_next == STALL_LAST);
   end

   // Register the previous pc every cycle; the counter only advances inside RUN
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_pc   <= '0;
         stall_cnt <= '0;
      end else begin
         prev_pc   <= pc;
         stall_cnt <= en ? cnt_next : '0;
      end
   end

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller for a RISC core: holds the core in reset for a fixed number
// of cycles, releases it, watches its pc and ends the run on a halt address,
// a self-loop stall or a watchdog expiry. The verdict is held until restart.
module risc_run_ctrl
   import risc_run_ctrl_pkg::*;
#(
   parameter int unsigned         PC_WIDTH     = DEF_PC_WIDTH,
   parameter int unsigned         CNT_WIDTH    = DEF_CNT_WIDTH,
   parameter int unsigned         RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int unsigned         MAX_CYCLES   = DEF_MAX_CYCLES,
   parameter int unsigned         STALL_LIMIT  = DEF_STALL_LIMIT,
   parameter logic [PC_WIDTH-1:0] HALT_PC      = PC_WIDTH'(DEF_HALT_PC)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  pc,
   output logic                 core_rst,
   output logic                 running,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   localparam logic [CNT_WIDTH-1:0]       LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);
   localparam logic [RESET_CNT_WIDTH-1:0] LAST_RESET = RESET_CNT_WIDTH'(RESET_CYCLES - 1);

   run_state_t                 state;
   logic [RESET_CNT_WIDTH-1:0] reset_cnt;
   logic                       stall_hit;
   end_cause_t                 cause;

   // running is high exactly in RUN, so it doubles as the detector enable
   risc_stall_detect #(
      .PC_WIDTH    (PC_WIDTH),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_detect (
      .clk       (clk),
      .rst       (rst),
      .en        (running),
      .pc        (pc),
      .stall_hit (stall_hit)
   );

   // Decide whether this RUN cycle ends the run, and why
   always_comb begin
      cause = END_NONE;
      if (state == ST_RUN)
         cause = pick_end(pc == HALT_PC, stall_hit, cycle_count == LAST_CYCLE);
   end

   // Run sequencing FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         reset_cnt   <= '0;
         core_rst    <= 1'b1;
         running     <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         stall       <= 1'b0;
         cycle_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state       <= ST_RESET;
                  reset_cnt   <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  timeout     <= 1'b0;
                  stall       <= 1'b0;
                  cycle_count <= '0;
               end
            end
            ST_RESET: begin
               if (reset_cnt == LAST_RESET) begin
                  state    <= ST_RUN;
                  core_rst <= 1'b0;
                  running  <= 1'b1;
               end else begin
                  reset_cnt <= reset_cnt + RESET_CNT_WIDTH'(1);
               end
            end
            ST_RUN: begin
               if (cause != END_NONE) begin
                  state    <= ST_DONE;
                  core_rst <= 1'b1;
                  running  <= 1'b0;
                  done     <= 1'b1;
                  pass     <= (cause == END_HALT);
                  stall    <= (cause == END_STALL);
                  timeout  <= (cause == END_TIMEOUT);
               end else begin
                  cycle_count <= cycle_count + CNT_WIDTH'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Self-checking bench for risc_run_ctrl: a behavioural model tracks the run
// phases by counting, directed scenarios cover halt, stall, timeout, priority,
// mid-run abort and restart, and a randomized phase stresses the rest.
module tb_risc_run_ctrl;

   localparam int          PCW = 16;
   localparam int          CW  = 32;
   localparam int          RC  = 4;
   localparam int          MC  = 100;
   localparam int          SL  = 8;
   localparam logic [15:0] HPC = 16'h0020;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   pc    = '0;
   logic          core_rst, running, done, pass, timeout, stall;
   logic [31:0]   cycle_count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   risc_run_ctrl #(
      .PC_WIDTH     (PCW),
      .CNT_WIDTH    (CW),
      .RESET_CYCLES (RC),
      .MAX_CYCLES   (MC),
      .STALL_LIMIT  (SL),
      .HALT_PC      (HPC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pc          (pc),
      .core_rst    (core_rst),
      .running     (running),
      .done        (done),
      .pass        (pass),
      .timeout     (timeout),
      .stall       (stall),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_reset_left = 0;   // RESET cycles still to go
   bit          m_run = 0, m_done = 0, m_pass = 0, m_stall = 0, m_tmo = 0;
   int          m_cycles = 0;       // RUN cycles completed
   int          m_streak = 0;       // consecutive unchanged-pc cycles in this run
   logic [15:0] m_last_pc = '0;
   bit          m_same, m_halt, m_st, m_to;
   int          m_streak_n;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_reset_left = 0; m_run = 0; m_done = 0;
         m_pass = 0; m_stall = 0; m_tmo = 0;
         m_cycles = 0; m_streak = 0; m_last_pc = '0;
      end else begin
         m_same    = (pc == m_last_pc);
         m_last_pc = pc;
         if (m_run) begin
            m_streak_n = m_same ? m_streak + 1 : 0;
            m_halt = (pc == HPC);
            m_st   = m_same && (m_streak_n == SL - 1);
            m_to   = (m_cycles == MC - 1);
            if (m_halt || m_st || m_to) begin
               m_run   = 0;
               m_done  = 1;
               m_pass  = m_halt;
               m_stall = !m_halt && m_st;
               m_tmo   = !m_halt && !m_st;
            end else begin
               m_cycles++;
            end
            m_streak = m_streak_n;
         end else if (m_reset_left > 0) begin
            m_reset_left--;
            if (m_reset_left == 0) begin
               m_run    = 1;
               m_streak = 0;
            end
         end else if (start) begin
            m_reset_left = RC;
            m_done = 0; m_pass = 0; m_stall = 0; m_tmo = 0;
            m_cycles = 0;
         end
      end
   end

   // Every cycle, away from the active edge, compare all outputs to the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("core_rst",    32'(core_rst),    32'(!m_run));
         check("running",     32'(running),     32'(m_run));
         check("done",        32'(done),        32'(m_done));
         check("pass",        32'(pass),        32'(m_pass));
         check("stall",       32'(stall),       32'(m_stall));
         check("timeout",     32'(timeout),     32'(m_tmo));
         check("cycle_count", cycle_count,      32'(m_cycles));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input bit s, input logic [15:0] p);
      start = s;
      pc    = p;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pc_for(input int mode, input int i);
      case (mode)
         0:       return 16'(i);                               // straight count to halt
         1:       return (i <= 5) ? 16'(i) : 16'd5;            // self-loop at 5
         2:       return 16'(i % 32);                          // wraps below HALT_PC
         3:       return (i < MC - 1) ? 16'(i % 32) : HPC;     // halt on the watchdog cycle
         default: return (i < MC - 8) ? 16'(i % 32) : 16'd7;   // stall on the watchdog cycle
      endcase
   endfunction

   // start pulse followed by the RESET window
   task automatic begin_run();
      tick(1'b1, pc);
      check("start_core_rst", 32'(core_rst), 32'd1);
      check("start_clears",   32'({done, pass, stall, timeout}), 32'd0);
      check("start_cc",       cycle_count, 32'd0);
      for (int k = 1; k <= RC; k++) begin
         tick(1'b0, 16'd0);
         check("reset_window", 32'(running), 32'(k == RC));
      end
      check("run_core_rst", 32'(core_rst), 32'd0);
   endtask

   task automatic run_mode(input int mode, input bit pulse_start);
      int i = 0;
      while (!done && i < 400) begin
         tick(pulse_start && (i % 7 == 3), pc_for(mode, i));
         i++;
      end
      check("run_ended", 32'(done), 32'd1);
   endtask

   task automatic verdict(input string tag, input bit p, input bit s, input bit t,
                          input int cc);
      check({tag, "_pass"},    32'(pass),    32'(p));
      check({tag, "_stall"},   32'(stall),   32'(s));
      check({tag, "_timeout"}, 32'(timeout), 32'(t));
      check({tag, "_cc"},      cycle_count,  32'(cc));
      check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_outputs",  32'({running, done, pass, timeout, stall}), 32'd0);
      check("rst_cc",       cycle_count, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // normal halt at pc 0x20
      begin_run();
      run_mode(0, 1'b0);
      verdict("halt", 1, 0, 0, 32);

      // DONE holds indefinitely
      repeat (6) tick(1'b0, 16'($urandom_range(0, 63)));
      check("hold_done", 32'(done), 32'd1);
      verdict("hold", 1, 0, 0, 32);

      // restart from DONE, start pulses during RUN ignored
      begin_run();
      run_mode(0, 1'b1);
      verdict("restart", 1, 0, 0, 32);

      // self-loop stall at pc 5: ends after the 8th cycle at 5
      begin_run();
      run_mode(1, 1'b0);
      verdict("stall", 0, 1, 0, 12);

      // watchdog
      begin_run();
      run_mode(2, 1'b0);
      verdict("timeout", 0, 0, 1, 99);

      // priority: halt over timeout, then stall over timeout
      begin_run();
      run_mode(3, 1'b0);
      verdict("prio_ht", 1, 0, 0, 99);
      begin_run();
      run_mode(4, 1'b0);
      verdict("prio_st", 0, 1, 0, 99);

      // abort mid-run at cycle_count 10
      begin_run();
      for (int i = 0; i < 10; i++) tick(1'b0, 16'(i));
      check("abort_cc_before", cycle_count, 32'd10);
      #1 rst = 1'b1;
      #1;
      check("abort_core_rst", 32'(core_rst), 32'd1);
      check("abort_outputs",  32'({running, done, pass, timeout, stall}), 32'd0);
      check("abort_cc",       cycle_count, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(1'b0, 16'd0);
      check("abort_idle", 32'({running, done}), 32'd0);
      begin_run();
      run_mode(0, 1'b0);
      verdict("after_abort", 1, 0, 0, 32);

      // randomized traffic, checked cycle by cycle against the model
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [15:0] np;
         r = $urandom_range(0, 9);
         if (r < 5)      np = pc;
         else if (r < 9) np = (pc + 16'd1) & 16'h003F;
         else            np = 16'($urandom_range(0, 63));
         if ($urandom_range(0, 299) == 0) rst = 1'b1;
         tick($urandom_range(0, 7) == 0, np);
         rst = 1'b0;
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
